contador_ffd_param: RTL and testbench

CONTADOR_FFD_PARAM -- requirements
Module: contador_ffd_param

---
 rtl/contador_ffd_param.sv | 80 ++++++++
 tb/tb_contador_ffd_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/contador_ffd_param.sv
// Parameterised up/down modulo counter with synchronous load, saturate-or-wrap
// boundaries, a one-cycle terminal pulse and a sticky boundary flag.
module contador_ffd_param #(
  parameter int unsigned ANCHO   = 4,
  parameter int unsigned MODULO  = 16,
  parameter int unsigned SATURAR = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_habilitar,
  input  logic             i_sentido,
  input  logic             i_cargar,
  input  logic [ANCHO-1:0] i_dato_carga,
  input  logic             i_limpiar,
  output logic [ANCHO-1:0] o_cuenta,
  output logic             o_fin,
  output logic             o_desborde
);

  localparam logic [ANCHO-1:0] MAXIMO = ANCHO'(MODULO - 1);
  localparam logic [ANCHO-1:0] CERO   = '0;
  localparam logic [ANCHO-1:0] UNO    = ANCHO'(1);
  localparam bit               SATURA = (SATURAR != 0);

  generate
    if (ANCHO < 2 || MODULO < 2 || MODULO > (64'd1 << ANCHO)) begin : g_param_check
      $error("contador_ffd_param: illegal ANCHO/MODULO combination");
    end
  endgenerate

  logic [ANCHO-1:0] siguiente;
  logic             evento;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    siguiente = o_cuenta;
    evento    = 1'b0;
    if (i_cargar) begin
      siguiente = (i_dato_carga > MAXIMO) ? MAXIMO : i_dato_carga;
    end else if (i_habilitar) begin
      if (i_sentido) begin
        // >= rather than == keeps the count inside 0..MODULO-1 even from a bad state
        if (o_cuenta >= MAXIMO) begin
          evento    = 1'b1;
          siguiente = SATURA ? MAXIMO : CERO;
        end else begin
          siguiente = o_cuenta + UNO;
        end
      end else begin
        if (o_cuenta == CERO) begin
          evento    = 1'b1;
          siguiente = SATURA ? CERO : MAXIMO;
        end else begin
          siguiente = o_cuenta - UNO;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the pre-edge values together, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cuenta   <= CERO;
      o_fin      <= 1'b0;
      o_desborde <= 1'b0;
    end else begin
      o_cuenta <= siguiente;
      o_fin    <= evento;
      // a boundary event outranks a same-edge clear
      if (evento) begin
        o_desborde <= 1'b1;
      end else if (i_limpiar) begin
        o_desborde <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_contador_ffd_param.sv
// Self-checking bench: one wrapping and one saturating counter (ANCHO=4,
// MODULO=10) driven by the same stimulus, checked from a vector table.
module tb_contador_ffd_param;

  typedef struct {
    logic       hab;
    logic       sen;
    logic       car;
    logic [3:0] dato;
    logic       lim;
    logic [3:0] c0;
    logic       f0;
    logic       d0;
    logic [3:0] c1;
    logic       f1;
    logic       d1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hab, sen, car, lim;
  logic [3:0] dato;
  logic [3:0] cuenta0, cuenta1;
  logic       fin0, fin1, desb0, desb1;

  int checks = 0;
  int errors = 0;
  int paso   = 0;

  vec_t tabla[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  contador_ffd_param #(.ANCHO(4), .MODULO(10), .SATURAR(0)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_habilitar(hab), .i_sentido(sen),
    .i_cargar(car), .i_dato_carga(dato), .i_limpiar(lim),
    .o_cuenta(cuenta0), .o_fin(fin0), .o_desborde(desb0)
  );

  contador_ffd_param #(.ANCHO(4), .MODULO(10), .SATURAR(1)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_habilitar(hab), .i_sentido(sen),
    .i_cargar(car), .i_dato_carga(dato), .i_limpiar(lim),
    .o_cuenta(cuenta1), .o_fin(fin1), .o_desborde(desb1)
  );

  task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wrap cuenta"}, cuenta0, 4'd0);
    check({tag, " wrap fin"}, {3'b0, fin0}, 4'd0);
    check({tag, " wrap desborde"}, {3'b0, desb0}, 4'd0);
    check({tag, " sat cuenta"}, cuenta1, 4'd0);
    check({tag, " sat fin"}, {3'b0, fin1}, 4'd0);
    check({tag, " sat desborde"}, {3'b0, desb1}, 4'd0);
  endtask

  task automatic compare_next();
    vec_t e;
    string tag;
    paso++;
    tag = $sformatf("step%0d", paso);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " wrap cuenta"}, cuenta0, e.c0);
      check({tag, " wrap fin"}, {3'b0, fin0}, {3'b0, e.f0});
      check({tag, " wrap desborde"}, {3'b0, desb0}, {3'b0, e.d0});
      check({tag, " sat cuenta"}, cuenta1, e.c1);
      check({tag, " sat fin"}, {3'b0, fin1}, {3'b0, e.f1});
      check({tag, " sat desborde"}, {3'b0, desb1}, {3'b0, e.d1});
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, compare.
  task automatic apply(input vec_t v);
    hab  = v.hab;
    sen  = v.sen;
    car  = v.car;
    dato = v.dato;
    lim  = v.lim;
    sb.push_back(v);
    @(posedge clk);
    #1;
    compare_next();
    @(negedge clk);
  endtask

  // Called at a falling edge: reset between edges, hold it across edges with
  // active inputs, release, and confirm the first enabled up edge gives 1.
  task automatic reset_mid_cycle(input string tag);
    hab  = 1'b1;
    sen  = 1'b1;
    car  = 1'b1;
    dato = 4'd7;
    lim  = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero({tag, " async"});
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_all_zero({tag, " held"});
    car   = 1'b0;
    rst_n = 1'b1;
    #1 check_all_zero({tag, " released"});
    apply('{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0});
  endtask

  initial begin
    // fields: hab sen car dato lim | wrap: cuenta fin desb | sat: cuenta fin desb
    for (int i = 1; i <= 9; i++) begin
      tabla.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'(i), 1'b0, 1'b0, 4'(i), 1'b0, 1'b0});
    end
    tabla.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b1}); // wrap 9->0 / sat hold
    tabla.push_back('{1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1}); // idle
    tabla.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1}); // clear vs set
    tabla.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd2, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1});
    tabla.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd3, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1});
    tabla.push_back('{1'b1, 1'b1, 1'b1, 4'd12, 1'b0, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1}); // load clamp
    tabla.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd8, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0});
    tabla.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    tabla.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd9, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1}); // down from 0
    tabla.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0}); // wrap + clear
    tabla.push_back('{1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0});
    tabla.push_back('{1'b1, 1'b1, 1'b1, 4'd3,  1'b0, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0}); // load beats enable
    tabla.push_back('{1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0});
    tabla.push_back('{1'b0, 1'b0, 1'b1, 4'd2,  1'b0, 4'd2, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0});
    tabla.push_back('{1'b0, 1'b0, 1'b1, 4'd10, 1'b0, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0});
    tabla.push_back('{1'b1, 1'b1, 1'b1, 4'd9,  1'b0, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0}); // load at top, no event
    tabla.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd8, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0});

    rst_n = 1'b0;
    hab   = 1'b0;
    sen   = 1'b0;
    car   = 1'b0;
    dato  = 4'd0;
    lim   = 1'b0;
    #12 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tabla[i]) apply(tabla[i]);

    // reset in the middle of a terminal-count pulse with desborde set
    apply('{1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0});
    apply('{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b1});
    reset_mid_cycle("pulse");

    // reset while counting at 5
    apply('{1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 4'd4, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0});
    apply('{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0});
    reset_mid_cycle("count5");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries left expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
